// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin two-master Wishbone arbiter with a bus watchdog.
module wb_bus_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int TIMEOUT = 256,
  localparam int SW = DW / 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_m0_cyc,
  input  logic          i_m0_stb,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_data,
  input  logic [SW-1:0] i_m0_sel,
  input  logic [2:0]    i_m0_cti,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  output logic [DW-1:0] o_m0_data,
  input  logic          i_m1_cyc,
  input  logic          i_m1_stb,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_data,
  input  logic [SW-1:0] i_m1_sel,
  input  logic [2:0]    i_m1_cti,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic [DW-1:0] o_m1_data,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  output logic [SW-1:0] o_wb_sel,
  output logic [2:0]    o_wb_cti,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data,
  output logic [1:0]    o_grant,
  output logic          o_timeout
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TOUT} state_t;
  localparam logic [15:0] LIM = 16'(TIMEOUT - 1);
  state_t state_q;
  logic last_q, pick, own_cyc, own_stb, hit, g0, g1, to;
  logic [15:0] cnt_q, cnt_d;
  // last_q doubles as the current owner while in GRANTx/TOUT
  assign pick = i_m1_cyc && (!i_m0_cyc || !last_q);
  assign own_cyc = last_q ? i_m1_cyc : i_m0_cyc;
  assign own_stb = last_q ? i_m1_stb : i_m0_stb;
  assign hit = own_stb && cnt_q == LIM && !i_wb_ack && !i_wb_err;
  assign cnt_d = ((state_q == GRANT0 || state_q == GRANT1) && !i_wb_ack && !i_wb_err)
               ? cnt_q + 16'(own_stb) : '0;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: if (i_m0_cyc || i_m1_cyc) begin
          state_q <= pick ? GRANT1 : GRANT0;
          last_q  <= pick;
        end
        GRANT0, GRANT1: state_q <= !own_cyc ? IDLE : hit ? TOUT : state_q;
        default: state_q <= IDLE;
      endcase
    end
  // reset dominates every output combinationally
  assign g0 = !i_rst && state_q == GRANT0;
  assign g1 = !i_rst && state_q == GRANT1;
  assign to = !i_rst && state_q == TOUT;
  assign o_wb_cyc  = g0 ? i_m0_cyc  : g1 ? i_m1_cyc  : 1'b0;
  assign o_wb_stb  = g0 ? i_m0_stb  : g1 ? i_m1_stb  : 1'b0;
  assign o_wb_we   = g0 ? i_m0_we   : g1 ? i_m1_we   : 1'b0;
  assign o_wb_addr = g0 ? i_m0_addr : g1 ? i_m1_addr : '0;
  assign o_wb_data = g0 ? i_m0_data : g1 ? i_m1_data : '0;
  assign o_wb_sel  = g0 ? i_m0_sel  : g1 ? i_m1_sel  : '0;
  assign o_wb_cti  = g0 ? i_m0_cti  : g1 ? i_m1_cti  : '0;
  assign o_m0_ack  = g0 && i_wb_ack;
  assign o_m1_ack  = g1 && i_wb_ack;
  assign o_m0_err  = (g0 && i_wb_err) || (to && !last_q);
  assign o_m1_err  = (g1 && i_wb_err) || (to && last_q);
  assign o_m0_data = i_rst ? '0 : i_wb_data;
  assign o_m1_data = i_rst ? '0 : i_wb_data;
  assign o_grant   = {g1, g0};
  assign o_timeout = to;
endmodule
